// File: rtl/spi_master_pkg.sv
// Shared constants, op codes and FSM encoding for the SPI master controller.
package spi_master_pkg;

    localparam int unsigned FRAME_BITS_DFLT = 10;
    localparam int unsigned DATA_BITS_DFLT  = 8;
    localparam int unsigned TMR_W           = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StShift,
        StWait,
        StCapture,
        StGap
    } state_e;

    // Read-data frames carry a zero payload whatever the host supplied.
    function automatic logic [FRAME_BITS_DFLT-1:0] build_frame(
        input logic [1:0]                op,
        input logic [DATA_BITS_DFLT-1:0] payload
    );
        return {op, (op == OP_RD_DATA) ? {DATA_BITS_DFLT{1'b0}} : payload};
    endfunction

endpackage

// File: rtl/spi_master_ctrl_shift.sv
// MOSI parallel-load/serial-out shifter, MISO serial-in capture register and shared bit counter.
module spi_master_shift
    import spi_master_pkg::*;
#(
    parameter int unsigned FRAME_BITS = FRAME_BITS_DFLT,
    parameter int unsigned DATA_BITS  = DATA_BITS_DFLT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [FRAME_BITS-1:0] frame_i,
    input  logic                  shift_i,
    input  logic                  capture_i,
    input  logic                  clr_cnt_i,
    input  logic                  miso_i,
    output logic                  mosi_bit_o,
    output logic [DATA_BITS-1:0]  cap_next_o,
    output logic [3:0]            bit_cnt_o
);

    logic [FRAME_BITS-1:0] sreg_q, sreg_d;
    // Holds the first DATA_BITS-1 samples; the last one is merged in cap_next_o.
    logic [DATA_BITS-2:0]  cap_q, cap_d;
    logic [3:0]            cnt_q, cnt_d;

    assign mosi_bit_o = sreg_q[FRAME_BITS-1];
    assign cap_next_o = {cap_q, miso_i};
    assign bit_cnt_o  = cnt_q;

    always_comb begin
        sreg_d = sreg_q;
        cap_d  = cap_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            sreg_d = frame_i;
            cnt_d  = '0;
        end else if (shift_i) begin
            sreg_d = {sreg_q[FRAME_BITS-2:0], 1'b0};
            cnt_d  = cnt_q + 4'd1;
        end else if (capture_i) begin
            cap_d = cap_next_o[DATA_BITS-2:0];
            cnt_d = cnt_q + 4'd1;
        end
        if (clr_cnt_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sreg_q <= '0;
            cap_q  <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cap_q  <= cap_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: one op per valid/ready handshake, 10-bit MOSI frame under SS_n, 8-bit read-back.
// Define SPI_MASTER_SEQ_CHECK_EN to drop out-of-sequence data ops and flag them on seq_err.
module spi_master_ctrl
    import spi_master_pkg::*;
#(
    parameter int unsigned FRAME_BITS = FRAME_BITS_DFLT,
    parameter int unsigned DATA_BITS  = DATA_BITS_DFLT,
    parameter int unsigned RD_WAIT    = 2,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [DATA_BITS-1:0] cmd_payload,
    output logic                 rd_valid,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 busy,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
`ifdef SPI_MASTER_SEQ_CHECK_EN
    ,
    output logic                 seq_err
`endif
);

    localparam logic [3:0]       LAST_TX_BIT = 4'(FRAME_BITS - 1);
    localparam logic [3:0]       LAST_RX_BIT = 4'(DATA_BITS - 1);
    localparam logic [TMR_W-1:0] WAIT_LAST   = TMR_W'(RD_WAIT - 1);
    localparam logic [TMR_W-1:0] GAP_LAST    = TMR_W'(GAP_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic                   is_rd_q, is_rd_d;
    logic                   ss_n_q, ss_n_d;
    logic                   mosi_q, mosi_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [DATA_BITS-1:0]   rd_data_q, rd_data_d;

    logic                   accept, send;
    logic                   load, shift, capture, clr_cnt;
    logic                   mosi_bit;
    logic [DATA_BITS-1:0]   cap_next;
    logic [3:0]             bit_cnt;
    logic [FRAME_BITS-1:0]  frame;

    assign frame = build_frame(cmd_op, cmd_payload);

`ifdef SPI_MASTER_SEQ_CHECK_EN
    logic wr_pend_q, wr_pend_d;
    logic rd_pend_q, rd_pend_d;
    logic seq_err_q, seq_err_d;
    logic seq_bad;

    always_comb begin
        accept    = cmd_valid && ready_q;
        seq_bad   = ((cmd_op == OP_WR_DATA) && !wr_pend_q) ||
                    ((cmd_op == OP_RD_DATA) && !rd_pend_q);
        send      = accept && !seq_bad;
        seq_err_d = accept && seq_bad;
        wr_pend_d = wr_pend_q;
        rd_pend_d = rd_pend_q;
        if (accept) begin
            case (cmd_op)
                OP_WR_ADDR: wr_pend_d = 1'b1;
                OP_WR_DATA: wr_pend_d = 1'b0;
                OP_RD_ADDR: rd_pend_d = 1'b1;
                default:    rd_pend_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            wr_pend_q <= wr_pend_d;
            rd_pend_q <= rd_pend_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign seq_err = seq_err_q;
`else
    always_comb begin
        accept = cmd_valid && ready_q;
        send   = accept;
    end
`endif

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        is_rd_d    = is_rd_q;
        mosi_d     = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        load       = 1'b0;
        shift      = 1'b0;
        capture    = 1'b0;
        clr_cnt    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (send) begin
                    load    = 1'b1;
                    mosi_d  = frame[FRAME_BITS-1];
                    is_rd_d = (cmd_op == OP_RD_DATA);
                    state_d = StStart;
                end
            end
            StStart: begin
                // The command-check cycle repeats the MSB; shifting starts with the counter at 0.
                shift   = 1'b1;
                clr_cnt = 1'b1;
                mosi_d  = mosi_bit;
                state_d = StShift;
            end
            StShift: begin
                if (bit_cnt != LAST_TX_BIT) begin
                    shift  = 1'b1;
                    mosi_d = mosi_bit;
                end else if (!is_rd_q) begin
                    tmr_d   = '0;
                    state_d = StGap;
                end else if (RD_WAIT == 0) begin
                    clr_cnt = 1'b1;
                    state_d = StCapture;
                end else begin
                    tmr_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (tmr_q == WAIT_LAST) begin
                    clr_cnt = 1'b1;
                    state_d = StCapture;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StCapture: begin
                capture = 1'b1;
                if (bit_cnt == LAST_RX_BIT) begin
                    rd_data_d  = cap_next;
                    rd_valid_d = 1'b1;
                    tmr_d      = '0;
                    state_d    = StGap;
                end
            end
            StGap: begin
                if (tmr_q == GAP_LAST) begin
                    state_d = StIdle;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        ss_n_d  = !((state_d == StStart) || (state_d == StShift) ||
                    (state_d == StWait)  || (state_d == StCapture));
        busy_d  = (state_d != StIdle);
        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            tmr_q      <= '0;
            is_rd_q    <= 1'b0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            is_rd_q    <= is_rd_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    spi_master_shift #(
        .FRAME_BITS (FRAME_BITS),
        .DATA_BITS  (DATA_BITS)
    ) u_shift (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (load),
        .frame_i    (frame),
        .shift_i    (shift),
        .capture_i  (capture),
        .clr_cnt_i  (clr_cnt),
        .miso_i     (MISO),
        .mosi_bit_o (mosi_bit),
        .cap_next_o (cap_next),
        .bit_cnt_o  (bit_cnt)
    );

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl with a behavioural SPI slave RAM on the far side.
module tb_spi_master_ctrl;

    localparam int RD_WAIT    = 2;
    localparam int GAP_CYCLES = 2;
    localparam int TX_CYC     = 11;
    localparam int RD_LAT     = 1 + 10 + RD_WAIT + 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_payload = 8'h00;
    logic       MISO;
    logic       cmd_ready, rd_valid, busy, SS_n, MOSI;
    logic [7:0] rd_data;
`ifdef SPI_MASTER_SEQ_CHECK_EN
    logic       seq_err;
`endif

    int errors = 0;
    int checks = 0;

    spi_master_ctrl #(
        .RD_WAIT    (RD_WAIT),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_payload (cmd_payload),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .busy        (busy),
        .SS_n        (SS_n),
        .MOSI        (MOSI),
        .MISO        (MISO)
`ifdef SPI_MASTER_SEQ_CHECK_EN
        ,
        .seq_err     (seq_err)
`endif
    );

    always #5 clk = ~clk;

    // Slave RAM: frame bits follow the command-check cycle; read byte goes out MSB-first
    // starting RD_WAIT cycles after the last frame bit.
    int unsigned sk = 0;
    logic [9:0]  s_frame = '0;
    logic [7:0]  s_ram [256];
    logic [7:0]  s_wr_ptr = '0, s_rd_ptr = '0, s_out = '0;

    initial begin
        for (int i = 0; i < 256; i++) s_ram[i] = 8'h00;
    end

    always @(negedge clk) begin
        if (SS_n !== 1'b0) begin
            sk   = 0;
            MISO = 1'b0;
        end else begin
            sk++;
            if (sk >= 2 && sk <= 11) s_frame = {s_frame[8:0], MOSI};
            if (sk == 11) begin
                case (s_frame[9:8])
                    2'b00:   s_wr_ptr = s_frame[7:0];
                    2'b01:   s_ram[s_wr_ptr] = s_frame[7:0];
                    2'b10:   s_rd_ptr = s_frame[7:0];
                    default: s_out = s_ram[s_rd_ptr];
                endcase
            end
            if (sk >= 12 + RD_WAIT && sk <= 19 + RD_WAIT) MISO = s_out[19 + RD_WAIT - sk];
            else MISO = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one op and check the whole frame it produces, up to cmd_ready returning.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [7:0] pl,
                         input logic [9:0] exp_frame, input logic exp_rd,
                         input logic [7:0] exp_dat);
        int          n = 0;
        int          ss_len = 0, ss_tot = 0, rdv_cnt = 0, rdv_t = -1, ready_t = -1;
        logic [10:0] bits = '0;
        logic [7:0]  rdv_dat = '0;
        logic        mosi_stray = 1'b0, busy_bad = 1'b0;
        int          exp_ss;
        exp_ss = exp_rd ? RD_LAT : TX_CYC;
        @(negedge clk);
        cmd_op = op;
        cmd_payload = pl;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check({tag, " accept"}, 32'(n < 64), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int t = 0; t < 48; t++) begin
            @(negedge clk);
            if (t < TX_CYC) bits = {bits[9:0], MOSI};
            else if (MOSI !== 1'b0) mosi_stray = 1'b1;
            if (SS_n === 1'b0) begin
                ss_tot++;
                if (ss_len == t) ss_len++;
            end
            if (rd_valid === 1'b1) begin
                rdv_cnt++;
                rdv_t = t;
                rdv_dat = rd_data;
            end
            if (busy !== !cmd_ready) busy_bad = 1'b1;
            if (cmd_ready === 1'b1) begin
                ready_t = t;
                break;
            end
        end
        check({tag, " mosi frame"}, 32'(bits), 32'({exp_frame[9], exp_frame}));
        check({tag, " mosi stray"}, 32'(mosi_stray), 32'd0);
        check({tag, " ss_n low run"}, ss_len, exp_ss);
        check({tag, " ss_n low total"}, ss_tot, exp_ss);
        check({tag, " ready return"}, ready_t, exp_ss + GAP_CYCLES);
        check({tag, " busy vs ready"}, 32'(busy_bad), 32'd0);
        check({tag, " rd_valid count"}, rdv_cnt, 32'(exp_rd));
        if (exp_rd) begin
            check({tag, " rd_valid latency"}, rdv_t, RD_LAT);
            check({tag, " rd_data"}, 32'(rdv_dat), 32'(exp_dat));
            check({tag, " rd_data hold"}, 32'(rd_data), 32'(exp_dat));
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] pl;
        logic [9:0] frame;
        logic       rd;
        logic [7:0] dat;
    } vec_t;

    vec_t       vt [10];
    logic [7:0] exp_mem [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{2'b00, 8'h01, 10'h001, 1'b0, 8'h00};
        vt[1] = '{2'b01, 8'h8A, 10'h18A, 1'b0, 8'h00};
        vt[2] = '{2'b10, 8'h01, 10'h201, 1'b0, 8'h00};
        vt[3] = '{2'b11, 8'h5C, 10'h300, 1'b1, 8'h8A};
        vt[4] = '{2'b00, 8'hFF, 10'h0FF, 1'b0, 8'h00};
        vt[5] = '{2'b01, 8'h3C, 10'h13C, 1'b0, 8'h00};
        vt[6] = '{2'b10, 8'hFF, 10'h2FF, 1'b0, 8'h00};
        vt[7] = '{2'b11, 8'hA5, 10'h300, 1'b1, 8'h3C};
        vt[8] = '{2'b10, 8'h01, 10'h201, 1'b0, 8'h00};
        vt[9] = '{2'b11, 8'hFF, 10'h300, 1'b1, 8'h8A};
        for (int i = 0; i < 8; i++) exp_mem[i] = 8'h00;

        // Reset then idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset ss_n", 32'(SS_n), 32'd1);
        check("reset mosi", 32'(MOSI), 32'd0);
        check("reset cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset rd_valid", 32'(rd_valid), 32'd0);
        check("reset rd_data", 32'(rd_data), 32'd0);

`ifdef SPI_MASTER_SEQ_CHECK_EN
        // Read-data with no read-addr pending is swallowed and flagged
        cmd_op = 2'b11;
        cmd_payload = 8'h00;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("seq_err pulse", 32'(seq_err), 32'd1);
        check("seq_err ss_n", 32'(SS_n), 32'd1);
        check("seq_err cmd_ready", 32'(cmd_ready), 32'd1);
        check("seq_err rd_valid", 32'(rd_valid), 32'd0);
        @(negedge clk);
        check("seq_err one cycle", 32'(seq_err), 32'd0);
        check("seq_err ss_n after", 32'(SS_n), 32'd1);
`endif

        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("vec%0d", i), vt[i].op, vt[i].pl, vt[i].frame, vt[i].rd, vt[i].dat);
        end

        // Back-pressure: held cmd_valid gives one acceptance per frame, 14 cycles apart
        begin
            int acc = 0, first = -1, second = -1, falls = 0;
            logic prev_ss = 1'b1;
            @(negedge clk);
            cmd_op = 2'b00;
            cmd_payload = 8'h42;
            cmd_valid = 1'b1;
            for (int i = 0; i < 28; i++) begin
                if (cmd_ready === 1'b1) begin
                    if (acc == 0) first = i;
                    else second = i;
                    acc++;
                end
                if (prev_ss === 1'b1 && SS_n === 1'b0) falls++;
                prev_ss = SS_n;
                @(negedge clk);
            end
            cmd_valid = 1'b0;
            check("backpressure accepts", acc, 2);
            check("backpressure spacing", second - first, TX_CYC + GAP_CYCLES + 1);
            check("backpressure frames", falls, 2);
        end

        // Reset during capture of the fifth bit
        do_op("rst rdaddr", 2'b10, 8'h01, 10'h201, 1'b0, 8'h00);
        begin
            int n = 0, rdv = 0;
            @(negedge clk);
            cmd_op = 2'b11;
            cmd_valid = 1'b1;
            while (cmd_ready !== 1'b1 && n < 64) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            repeat (18) @(negedge clk);
            check("mid-capture ss_n low", 32'(SS_n), 32'd0);
            #2 rst = 1'b1;
            #1;
            check("abort ss_n", 32'(SS_n), 32'd1);
            check("abort mosi", 32'(MOSI), 32'd0);
            check("abort rd_data", 32'(rd_data), 32'd0);
            check("abort busy", 32'(busy), 32'd0);
            check("abort cmd_ready", 32'(cmd_ready), 32'd1);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            for (int t = 0; t < 30; t++) begin
                @(negedge clk);
                if (rd_valid === 1'b1) rdv++;
            end
            check("abort no rd_valid", rdv, 0);
            check("abort rd_data stays", 32'(rd_data), 32'd0);
        end
        do_op("post-rst rdaddr", 2'b10, 8'h01, 10'h201, 1'b0, 8'h00);
        do_op("post-rst rddata", 2'b11, 8'h77, 10'h300, 1'b1, 8'h8A);

        // Random legal pairs against a plain memory model
        for (int k = 0; k < 12; k++) begin
            logic [7:0] addr, dat, junk;
            addr = 8'(8'h10 + $urandom_range(0, 7));
            dat  = 8'($urandom_range(0, 255));
            junk = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                do_op($sformatf("rnd%0d wa", k), 2'b00, addr, {2'b00, addr}, 1'b0, 8'h00);
                do_op($sformatf("rnd%0d wd", k), 2'b01, dat, {2'b01, dat}, 1'b0, 8'h00);
                exp_mem[addr - 8'h10] = dat;
            end else begin
                do_op($sformatf("rnd%0d ra", k), 2'b10, addr, {2'b10, addr}, 1'b0, 8'h00);
                do_op($sformatf("rnd%0d rd", k), 2'b11, junk, 10'h300, 1'b1,
                      exp_mem[addr - 8'h10]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
